cp0_regfile: RTL and testbench

Coprocessor-0 register file for the MIPS pipeline. It is the consumer of the MEM-stage exception decoder's outputs. It records exception state (EPC, Cause.ExcCode, Cause.BD, BadVAddr, Status.EXL), clears EXL on ERET, and serves MTC0/MFC0 accesses. It also runs the Count/Compare timer, and feeds the current Status, Cause and EPC back to the decoder for interrupt detection and ERET targeting.

---
 rtl/cp0_regfile_pkg.sv | 70 +++++++
 rtl/cp0_regfile_timer.sv | 82 ++++++++
 rtl/cp0_regfile.sv | 181 ++++++++++++++++++
 tb/tb_cp0_regfile.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// cp0_defs: shared CP0 definitions.
// Holds the CP0 register numbers, the ExcCode values and the except_type
// encodings used by the exception decoder. It also holds the Status/Cause bit
// positions and a helper that maps an except_type to its ExcCode.
package cp0_defs;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // except_type encodings produced by the MEM-stage exception decoder
  localparam logic [31:0] ET_INT  = 32'h0000_0001;
  localparam logic [31:0] ET_ADEL = 32'h0000_0004;
  localparam logic [31:0] ET_ADES = 32'h0000_0005;
  localparam logic [31:0] ET_SYS  = 32'h0000_0008;
  localparam logic [31:0] ET_BP   = 32'h0000_0009;
  localparam logic [31:0] ET_RI   = 32'h0000_000a;
  localparam logic [31:0] ET_OV   = 32'h0000_000c;
  localparam logic [31:0] ET_ERET = 32'h0000_000e;

  // Status / Cause bit positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_BEV   = 22;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IP_HW  = 10;
  localparam int unsigned CAUSE_IP7    = 15;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_map_t;

  // Map an except_type to its ExcCode. valid=0 covers none, ERET and unknown types.
  function automatic exc_map_t map_except(input logic [31:0] et);
    exc_map_t m;
    m.valid = 1'b1;
    m.code  = EXC_INT;
    case (et)
      ET_INT:  m.code = EXC_INT;
      ET_ADEL: m.code = EXC_ADEL;
      ET_ADES: m.code = EXC_ADES;
      ET_SYS:  m.code = EXC_SYS;
      ET_BP:   m.code = EXC_BP;
      ET_RI:   m.code = EXC_RI;
      ET_OV:   m.code = EXC_OV;
      default: m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: the CP0 Count/Compare timer.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   count_we_i      load Count from wdata_i; restarts the tick phase
//   compare_we_i    load Compare from wdata_i; clears timer_int
//   wdata_i         write data
//   count_o         current Count value
//   compare_o       current Compare value
//   timer_int_o     sticky timer interrupt
module cp0_timer #(
  parameter bit COUNT_DIV2 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_d, count_q;
  logic [31:0] compare_d, compare_q;
  logic        phase_d, phase_q;
  logic        tint_d, tint_q;
  logic        tick_s;
  logic [31:0] count_inc_s;

  // Next-state logic for Count, Compare, the tick phase and timer_int
  always_comb begin
    // In divide-by-2 mode Count advances on every cycle where phase was 1.
    tick_s      = COUNT_DIV2 ? phase_q : 1'b1;
    count_inc_s = count_q + 32'd1;
    count_d     = count_q;
    compare_d   = compare_q;
    phase_d     = ~phase_q;
    tint_d      = tint_q;
    if (count_we_i) begin
      // A software load replaces this edge's increment.
      count_d = wdata_i;
      phase_d = 1'b0;
    end else if (tick_s) begin
      count_d = count_inc_s;
      if (count_inc_s == compare_q) begin
        tint_d = 1'b1;
      end else begin
        tint_d = tint_q;
      end
    end else begin
      count_d = count_q;
    end
    // Writing Compare acknowledges the timer interrupt. This clear wins over
    // a match on the same edge.
    if (compare_we_i) begin
      compare_d = wdata_i;
      tint_d    = 1'b0;
    end else begin
      compare_d = compare_q;
    end
  end

  // Timer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      phase_q   <= 1'b0;
      tint_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      phase_q   <= phase_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS coprocessor-0 register file.
// It records exception state and clears EXL on ERET. It serves MTC0 writes
// and MFC0 reads, runs the Count/Compare timer through cp0_timer, and exposes
// Status, Cause and EPC back to the exception decoder.
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   we_i/waddr_i/wdata_i            MTC0 write port
//   raddr_i/rdata_o                 MFC0 read port; rdata_o is combinational from state
//   ext_int_i                       level-sensitive hardware interrupt lines
//   except_type_i, current_pc_i,
//   is_in_delayslot_i, bad_addr_i   exception event from the MEM stage
//   status_o ... compare_o          current register values
//   timer_int_o                     timer interrupt pending
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h00004220,
  parameter bit          COUNT_DIV2 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  ext_int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [7:0]  im_d, im_q;
  logic        exl_d, exl_q;
  logic        ie_d, ie_q;
  logic        bd_d, bd_q;
  logic [4:0]  exccode_d, exccode_q;
  logic [5:0]  ip_hw_d, ip_hw_q;
  logic [1:0]  ip_sw_d, ip_sw_q;
  logic [31:0] epc_d, epc_q;
  logic [31:0] badvaddr_d, badvaddr_q;
  exc_map_t    emap_s;
  logic        is_eret_s;
  logic        mtc0_en_s;
  logic        count_we_s, compare_we_s;
  logic        timer_int_s;

  // Exception/ERET decode, and MTC0 gating, which loses to any exception event
  always_comb begin
    emap_s       = map_except(except_type_i);
    is_eret_s    = (except_type_i == ET_ERET);
    mtc0_en_s    = we_i & ~(emap_s.valid | is_eret_s);
    count_we_s   = mtc0_en_s & (waddr_i == CP0_COUNT);
    compare_we_s = mtc0_en_s & (waddr_i == CP0_COMPARE);
  end

  // Next-state logic for Status, Cause, EPC and BadVAddr
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_hw_d    = ext_int_i;
    if (emap_s.valid) begin
      exccode_d = emap_s.code;
      exl_d     = 1'b1;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = is_in_delayslot_i ? (current_pc_i - 32'd4) : current_pc_i;
        bd_d  = is_in_delayslot_i;
      end else begin
        epc_d = epc_q;
        bd_d  = bd_q;
      end
      if ((except_type_i == ET_ADEL) || (except_type_i == ET_ADES)) begin
        badvaddr_d = bad_addr_i;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (is_eret_s) begin
      exl_d = 1'b0;
    end else if (mtc0_en_s) begin
      case (waddr_i)
        CP0_STATUS: begin
          im_d  = wdata_i[STATUS_IM_LO +: 8];
          exl_d = wdata_i[STATUS_EXL];
          ie_d  = wdata_i[STATUS_IE];
        end
        CP0_CAUSE: ip_sw_d = wdata_i[CAUSE_IP_LO +: 2];
        CP0_EPC:   epc_d   = wdata_i;
        default:   ip_sw_d = ip_sw_q;
      endcase
    end else begin
      im_d = im_q;
    end
  end

  // CP0 state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  cp0_timer #(.COUNT_DIV2(COUNT_DIV2)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (count_we_s),
    .compare_we_i (compare_we_s),
    .wdata_i      (wdata_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .timer_int_o  (timer_int_s)
  );

  // Assemble the architectural Status/Cause views from the stored fields
  always_comb begin
    status_o                       = 32'd0;
    status_o[STATUS_BEV]           = 1'b1;
    status_o[STATUS_IM_LO +: 8]    = im_q;
    status_o[STATUS_EXL]           = exl_q;
    status_o[STATUS_IE]            = ie_q;
    cause_o                        = 32'd0;
    cause_o[CAUSE_BD]              = bd_q;
    cause_o[CAUSE_TI]              = timer_int_s;
    // IP7 is shared between hardware line 5 and the timer.
    cause_o[CAUSE_IP7]             = ip_hw_q[5] | timer_int_s;
    cause_o[CAUSE_IP_HW +: 5]      = ip_hw_q[4:0];
    cause_o[CAUSE_IP_LO +: 2]      = ip_sw_q;
    cause_o[CAUSE_EXC_LO +: 5]     = exccode_q;
  end

  // MFC0 read mux selecting the addressed CP0 register, zero for other numbers
  always_comb begin
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count_o;
      CP0_COMPARE:  rdata_o = compare_o;
      CP0_STATUS:   rdata_o = status_o;
      CP0_CAUSE:    rdata_o = cause_o;
      CP0_EPC:      rdata_o = epc_q;
      CP0_PRID:     rdata_o = PRID_VALUE;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int_s;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile. The stimulus process pushes the expected
// post-edge state from a behavioural model. A negedge monitor pops that state
// and compares it with the DUT outputs.
module tb_cp0_regfile;
  localparam logic [31:0] PRID = 32'h00004220;

  logic        clk = 1'b0;
  logic        rst, we_i, is_in_delayslot_i, timer_int_o;
  logic [4:0]  waddr_i, raddr_i;
  logic [5:0]  ext_int_i;
  logic [31:0] wdata_i, rdata_o, except_type_i, current_pc_i, bad_addr_i;
  logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;

  cp0_regfile #(.PRID_VALUE(PRID), .COUNT_DIV2(1'b1)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .ext_int_i(ext_int_i),
    .except_type_i(except_type_i), .current_pc_i(current_pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .count_o(count_o), .compare_o(compare_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] status, cause, epc, badvaddr, count, compare, rdata;
    logic        ti;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Behavioural model: architectural fields kept as plain variables.
  logic [31:0] m_epc, m_bad, m_count, m_compare;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_code;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  int          m_age;      // edges since reset or the last Count load
  int          exc_tab[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'h0000, m_im, 6'b000000, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'h0000, m_hw[5] | m_ti, m_hw[4:0], m_sw, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_step();
    logic exc, eret, wr, tick;
    int   et;
    if (rst) begin
      m_epc = 32'd0; m_bad = 32'd0; m_count = 32'd0; m_compare = 32'd0;
      m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
      m_code = 5'd0; m_hw = 6'd0; m_sw = 2'd0; m_age = 0;
    end else begin
      et   = int'(except_type_i);
      exc  = exc_tab.exists(et);
      eret = (except_type_i == 32'h0000_000e);
      wr   = we_i && !exc && !eret;
      tick = (m_age % 2) == 1;
      if (wr && waddr_i == 5'd9) begin
        m_count = wdata_i;
        m_age   = 0;
      end else begin
        m_age++;
        if (tick) begin
          m_count = m_count + 32'd1;
          if (m_count == m_compare) m_ti = 1'b1;
        end
      end
      if (wr && waddr_i == 5'd11) begin
        m_compare = wdata_i;
        m_ti      = 1'b0;
      end
      m_hw = ext_int_i;
      if (exc) begin
        m_code = 5'(exc_tab[et]);
        if (!m_exl) begin
          m_epc = is_in_delayslot_i ? current_pc_i - 32'd4 : current_pc_i;
          m_bd  = is_in_delayslot_i;
        end
        m_exl = 1'b1;
        if (et == 4 || et == 5) m_bad = bad_addr_i;
      end else if (eret) begin
        m_exl = 1'b0;
      end else if (wr) begin
        case (waddr_i)
          5'd12: begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
          5'd13: m_sw = wdata_i[9:8];
          5'd14: m_epc = wdata_i;
          default: ;
        endcase
      end
    end
  endtask

  // One clock: the DUT samples the driven inputs, the model follows, and the
  // expected state is queued. Inputs may change again from negedge+1.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    e.status = m_status(); e.cause = m_cause(); e.epc = m_epc; e.badvaddr = m_bad;
    e.count = m_count; e.compare = m_compare; e.ti = m_ti; e.rdata = m_read(raddr_i);
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0;
    except_type_i = 32'd0; current_pc_i = 32'd0; is_in_delayslot_i = 1'b0;
    bad_addr_i = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we_i = 1'b1; waddr_i = a; wdata_i = d; cycle(); idle();
  endtask

  task automatic excp(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                      input logic [31:0] ba);
    idle(); except_type_i = t; current_pc_i = pc; is_in_delayslot_i = ds;
    bad_addr_i = ba; cycle(); idle();
  endtask

  // Monitor: compare the DUT outputs with the oldest queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("status", status_o, mon_e.status);
      chk("cause", cause_o, mon_e.cause);
      chk("epc", epc_o, mon_e.epc);
      chk("badvaddr", badvaddr_o, mon_e.badvaddr);
      chk("count", count_o, mon_e.count);
      chk("compare", compare_o, mon_e.compare);
      chk("timer_int", {31'd0, timer_int_o}, {31'd0, mon_e.ti});
      chk("rdata", rdata_o, mon_e.rdata);
    end
  end

  // Watchdog: the run must never hang
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] et_pool [10];
  logic [4:0]  wa_pool [7];

  // Main stimulus: directed scenarios followed by random traffic
  initial begin
    exc_tab[1] = 0; exc_tab[4] = 4; exc_tab[5] = 5; exc_tab[8] = 8;
    exc_tab[9] = 9; exc_tab[10] = 10; exc_tab[12] = 12;
    et_pool = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h22};
    wa_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    idle(); raddr_i = 5'd12; ext_int_i = 6'd0;

    rst = 1'b1; cycle(); idle();
    chk("reset_status", status_o, 32'h0040_0000);
    chk("reset_cause", cause_o, 32'd0);
    chk("reset_timer", {31'd0, timer_int_o}, 32'd0);

    excp(32'h8, 32'hBFC0_0100, 1'b0, 32'd0);
    chk("sys_epc", epc_o, 32'hBFC0_0100);
    chk("sys_cause", cause_o & 32'h8000_007c, 32'h0000_0020);
    chk("sys_exl", status_o & 32'h2, 32'h2);
    excp(32'he, 32'd0, 1'b0, 32'd0);

    raddr_i = 5'd8;
    excp(32'h4, 32'h8000_0010, 1'b1, 32'h8000_0013);
    chk("adel_epc", epc_o, 32'h8000_000C);
    chk("adel_bd", cause_o & 32'h8000_0000, 32'h8000_0000);
    chk("adel_bad", badvaddr_o, 32'h8000_0013);
    excp(32'ha, 32'h1234_5678, 1'b0, 32'hdead_beef);
    chk("nested_epc", epc_o, 32'h8000_000C);
    chk("nested_cause", cause_o & 32'h8000_007c, 32'h8000_0028);
    excp(32'he, 32'd0, 1'b0, 32'd0);
    chk("eret_exl", status_o & 32'h2, 32'h0);

    raddr_i = 5'd12;
    idle(); we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_FF01;
    except_type_i = 32'hc; current_pc_i = 32'h0000_0040; cycle(); idle();
    chk("collide_status", status_o, 32'h0040_0002);
    chk("collide_code", cause_o & 32'h7c, 32'h30);
    excp(32'he, 32'd0, 1'b0, 32'd0);

    raddr_i = 5'd9;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    repeat (8) cycle();
    chk("timer_early", {31'd0, timer_int_o}, 32'd0);
    cycle();
    chk("timer_rise", {31'd0, timer_int_o}, 32'd1);
    chk("timer_ip_ti", cause_o & 32'h4000_8000, 32'h4000_8000);
    mtc0(5'd11, 32'd100);
    chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    cycle(); cycle();
    chk("count_wrap", count_o, 32'd0);

    raddr_i = 5'd13;
    ext_int_i = 6'b000010; cycle();
    chk("ext_ip3", cause_o & 32'h800, 32'h800);
    ext_int_i = 6'd0;
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_sw_ip", cause_o & 32'h3fff_ff00, 32'h0000_0300);
    raddr_i = 5'd15; cycle();
    chk("prid", rdata_o, PRID);

    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      raddr_i = 5'($urandom_range(0, 31));
      ext_int_i = 6'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        we_i = 1'b1;
        waddr_i = ($urandom_range(0, 7) == 0) ? 5'($urandom) : wa_pool[$urandom_range(0, 6)];
        wdata_i = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 3) == 0) begin
        except_type_i = et_pool[$urandom_range(0, 9)];
        current_pc_i = $urandom;
        is_in_delayslot_i = 1'($urandom);
        bad_addr_i = $urandom;
      end
      cycle();
    end
    idle();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
